// File: rtl/colordetect_accel_prod_accum.sv
// colordetect_accel_prod_accum
// Sums the 32-bit unsigned products of the colordetect product pipeline
// per in_last-delimited segment. Each finished segment is reported as sum,
// beat count, maximum product and overflow flag through a one-entry
// ready/valid result slot.
//
// Build option: define COLORDETECT_PROD_ACCUM_SAT_EN to make the sum and
// the beat count clamp at their all-ones value on carry-out. Without it
// they wrap. The overflow flag is raised in both builds.
module colordetect_accel_prod_accum #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic [31:0]      out_max,
  output logic             out_ovf
);

  // The result slot is either free or holding an unconsumed result.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Working registers of the segment in progress.
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mx_q, mx_d;
  logic             ovf_q, ovf_d;

  // Result slot.
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [31:0]      out_max_q, out_max_d;
  logic             out_ovf_q, out_ovf_d;

  // Combinational intermediates.
  logic             accept_s;
  logic             last_accept_s;
  logic [ACC_W:0]   acc_sum_s;
  logic [CNT_W:0]   cnt_sum_s;
  logic [ACC_W-1:0] acc_upd_s;
  logic [CNT_W-1:0] cnt_upd_s;
  logic [31:0]      mx_upd_s;
  logic             ovf_upd_s;

  // Input is taken whenever the slot is free or is being emptied this cycle.
  assign in_ready      = (state_q == ST_EMPTY) || out_ready;
  assign accept_s      = in_valid && in_ready;
  assign last_accept_s = accept_s && in_last;

  // Registered outputs.
  assign out_valid = (state_q == ST_FULL);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_max   = out_max_q;
  assign out_ovf   = out_ovf_q;

  // Working values including the current beat, with carry detection.
  always_comb begin
    acc_sum_s = {1'b0, acc_q} + {{(ACC_W-31){1'b0}}, in_data};
    cnt_sum_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
`ifdef COLORDETECT_PROD_ACCUM_SAT_EN
    // Once clamped, further non-negative additions keep clamping.
    if (acc_sum_s[ACC_W]) begin
      acc_upd_s = {ACC_W{1'b1}};
    end else begin
      acc_upd_s = acc_sum_s[ACC_W-1:0];
    end
    if (cnt_sum_s[CNT_W]) begin
      cnt_upd_s = {CNT_W{1'b1}};
    end else begin
      cnt_upd_s = cnt_sum_s[CNT_W-1:0];
    end
`else
    acc_upd_s = acc_sum_s[ACC_W-1:0];
    cnt_upd_s = cnt_sum_s[CNT_W-1:0];
`endif
    if (in_data > mx_q) begin
      mx_upd_s = in_data;
    end else begin
      mx_upd_s = mx_q;
    end
    ovf_upd_s = ovf_q | acc_sum_s[ACC_W] | cnt_sum_s[CNT_W];
  end

  // Slot state: load on a last-beat accept (also during a pop), free on pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (last_accept_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (last_accept_s) begin
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Working and result register updates; the slot only changes on a last accept.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mx_d        = mx_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_max_d   = out_max_q;
    out_ovf_d   = out_ovf_q;
    if (last_accept_s) begin
      out_sum_d   = acc_upd_s;
      out_count_d = cnt_upd_s;
      out_max_d   = mx_upd_s;
      out_ovf_d   = ovf_upd_s;
      acc_d       = {ACC_W{1'b0}};
      cnt_d       = {CNT_W{1'b0}};
      mx_d        = 32'd0;
      ovf_d       = 1'b0;
    end else if (accept_s) begin
      acc_d = acc_upd_s;
      cnt_d = cnt_upd_s;
      mx_d  = mx_upd_s;
      ovf_d = ovf_upd_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // State, working and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      mx_q        <= 32'd0;
      ovf_q       <= 1'b0;
      out_sum_q   <= {ACC_W{1'b0}};
      out_count_q <= {CNT_W{1'b0}};
      out_max_q   <= 32'd0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mx_q        <= mx_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_max_q   <= out_max_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_colordetect_accel_prod_accum.sv
// Testbench for colordetect_accel_prod_accum. Two instances (default widths
// and ACC_W=33/CNT_W=2) receive identical stimulus; a reference model
// computes each segment result from the collected beats and queues it, and
// a monitor compares whatever the instances present.
module tb_colordetect_accel_prod_accum;

  localparam int A0 = 48;
  localparam int C0 = 24;
  localparam int A1 = 33;
  localparam int C1 = 2;

  typedef struct {
    logic [63:0] sum;
    logic [31:0] cnt;
    logic [31:0] mx;
    logic        ovf;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = 32'd0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready0, in_ready1, out_valid0, out_valid1;
  logic [A0-1:0] out_sum0;
  logic [C0-1:0] out_count0;
  logic [A1-1:0] out_sum1;
  logic [C1-1:0] out_count1;
  logic [31:0]   out_max0, out_max1;
  logic          out_ovf0, out_ovf1;

  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  logic accept_exp = 1'b0;
  logic [31:0] seg[$];
  res_t q0[$];
  res_t q1[$];
  res_t last0, last1;

  colordetect_accel_prod_accum #(.ACC_W(A0), .CNT_W(C0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_sum(out_sum0), .out_count(out_count0),
    .out_max(out_max0), .out_ovf(out_ovf0)
  );

  colordetect_accel_prod_accum #(.ACC_W(A1), .CNT_W(C1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_sum(out_sum1), .out_count(out_count1),
    .out_max(out_max1), .out_ovf(out_ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Segment result from the plain arithmetic of all beats in the segment.
  function automatic res_t model(input int aw, input int cw);
    res_t r;
    logic [95:0] total;
    logic [95:0] amax;
    logic [63:0] n;
    logic [63:0] cmax;
    logic [31:0] m;
    total = 96'd0;
    m     = 32'd0;
    n     = 64'(seg.size());
    foreach (seg[i]) begin
      total = total + {64'd0, seg[i]};
      if (seg[i] > m) m = seg[i];
    end
    amax  = (96'd1 << aw) - 96'd1;
    cmax  = (64'd1 << cw) - 64'd1;
    r.ovf = (total > amax) || (n > cmax);
`ifdef COLORDETECT_PROD_ACCUM_SAT_EN
    r.sum = (total > amax) ? amax[63:0] : total[63:0];
    r.cnt = (n > cmax) ? cmax[31:0] : n[31:0];
`else
    r.sum = total[63:0] & amax[63:0];
    r.cnt = n[31:0] & cmax[31:0];
`endif
    r.mx = m;
    return r;
  endfunction

  // Reference model: collect accepted beats, queue a result on each last beat.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      seg.delete();
      q0.delete();
      q1.delete();
    end else if (accept_exp) begin
      seg.push_back(in_data);
      if (in_last) begin
        q0.push_back(model(A0, C0));
        q1.push_back(model(A1, C1));
        seg.delete();
      end
    end
  end

  // Monitor: handshake check, slot contents against the queue head, pop on transfer.
  always @(negedge clk) begin
    logic exp_rdy;
    res_t e;
    if (cyc > 0) begin
      exp_rdy = (q0.size() == 0) || out_ready;
      chk("in_ready0", {63'd0, in_ready0}, {63'd0, exp_rdy});
      chk("in_ready1", {63'd0, in_ready1}, {63'd0, exp_rdy});
      accept_exp = in_valid && exp_rdy && !reset;
      chk("out_valid0", {63'd0, out_valid0}, {63'd0, q0.size() != 0});
      chk("out_valid1", {63'd0, out_valid1}, {63'd0, q1.size() != 0});
      if (out_valid0 && q0.size() != 0) begin
        e = q0[0];
        chk("sum0", {16'd0, out_sum0}, e.sum);
        chk("count0", {40'd0, out_count0}, {32'd0, e.cnt});
        chk("max0", {32'd0, out_max0}, {32'd0, e.mx});
        chk("ovf0", {63'd0, out_ovf0}, {63'd0, e.ovf});
        if (out_ready && !reset) begin
          last0 = e;
          void'(q0.pop_front());
        end
      end
      if (out_valid1 && q1.size() != 0) begin
        e = q1[0];
        chk("sum1", {31'd0, out_sum1}, e.sum);
        chk("count1", {62'd0, out_count1}, {32'd0, e.cnt});
        chk("max1", {32'd0, out_max1}, {32'd0, e.mx});
        chk("ovf1", {63'd0, out_ovf1}, {63'd0, e.ovf});
        if (out_ready && !reset) begin
          last1 = e;
          void'(q1.pop_front());
        end
      end
    end
  end

  // Present one beat and hold it until accepted; rmode 0/1 fixed out_ready, 2 random.
  task automatic beat(input logic [31:0] d, input logic l, input int rmode);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!done) begin
      if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (rmode == 1);
      @(posedge clk);
      if (accept_exp) begin
        done = 1'b1;
      end else begin
        n++;
        if (n >= 200) begin
          n_total++;
          $display("FAIL beat_timeout: beat %0h not accepted after %0d cycles", d, n);
          done = 1'b1;
        end
      end
      #1;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (q0.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q0.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results still pending", q0.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_last(input string name, input res_t act, input logic [63:0] s,
                             input logic [31:0] c, input logic [31:0] m, input logic o);
    chk({name, "_sum"}, act.sum, s);
    chk({name, "_cnt"}, {32'd0, act.cnt}, {32'd0, c});
    chk({name, "_max"}, {32'd0, act.mx}, {32'd0, m});
    chk({name, "_ovf"}, {63'd0, act.ovf}, {63'd0, o});
  endtask

  initial begin
    int len;
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("rst_sum", {16'd0, out_sum0}, 64'd0);
    chk("rst_count", {40'd0, out_count0}, 64'd0);
    chk("rst_max", {32'd0, out_max0}, 64'd0);
    chk("rst_ovf", {63'd0, out_ovf1}, 64'd0);
    reset = 1'b0;

    // Basic three-beat segment.
    beat(32'd10, 1'b0, 1);
    beat(32'd20, 1'b0, 1);
    beat(32'd30, 1'b1, 1);
    drain();
    expect_last("basic0", last0, 64'd60, 32'd3, 32'd30, 1'b0);
    expect_last("basic1", last1, 64'd60, 32'd3, 32'd30, 1'b0);

    // Single-beat segment at full scale.
    beat(32'hFFFF_FFFF, 1'b1, 1);
    drain();
    expect_last("single0", last0, 64'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);

    // Stall with a pending result, then pop and reload in the same cycle.
    beat(32'd100, 1'b0, 1);
    beat(32'd200, 1'b1, 1);
    in_valid  = 1'b1;
    in_data   = 32'd7;
    in_last   = 1'b1;
    out_ready = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    beat(32'd7, 1'b1, 1);
    drain();
    expect_last("reload0", last0, 64'd7, 32'd1, 32'd7, 1'b0);

    // Sum overflow on the 33-bit instance.
    beat(32'hFFFF_FFFF, 1'b0, 1);
    beat(32'hFFFF_FFFF, 1'b0, 1);
    beat(32'hFFFF_FFFF, 1'b1, 1);
    drain();
`ifdef COLORDETECT_PROD_ACCUM_SAT_EN
    expect_last("accovf1", last1, 64'h1_FFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 1'b1);
`else
    expect_last("accovf1", last1, 64'h0_FFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 1'b1);
`endif
    expect_last("accovf0", last0, 64'h2_FFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 1'b0);

    // Count overflow on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) beat(32'd1, (i == 4), 1);
    drain();
`ifdef COLORDETECT_PROD_ACCUM_SAT_EN
    expect_last("cntovf1", last1, 64'd5, 32'd3, 32'd1, 1'b1);
`else
    expect_last("cntovf1", last1, 64'd5, 32'd1, 32'd1, 1'b1);
`endif
    expect_last("cntovf0", last0, 64'd5, 32'd5, 32'd1, 1'b0);

    // Reset in the middle of a segment discards it.
    beat(32'd1000, 1'b0, 1);
    beat(32'd2000, 1'b0, 1);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    beat(32'd5, 1'b0, 1);
    beat(32'd7, 1'b1, 1);
    drain();
    expect_last("abort0", last0, 64'd12, 32'd2, 32'd7, 1'b0);
    expect_last("abort1", last1, 64'd12, 32'd2, 32'd7, 1'b0);

    // Randomized segments with random backpressure and idle gaps.
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
        beat(d, (b == len - 1), 2);
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
